// File: rtl/fifo_uart_tx_if.sv
// Bundle between the byte FIFO read port, the TX control input and the UART line.
// The master side (FIFO/system) drives the inputs and the slave side (transmitter) drives the rest.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             tx_enable;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;
  logic             serial_out;
  logic             busy;

  modport master (
    output tx_enable,
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en,
    input  serial_out,
    input  busy
  );

  modport slave (
    input  tx_enable,
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en,
    output serial_out,
    output busy
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and serializes each as an 8N1-style UART frame (start, WIDTH data LSB first, stop).
// The FIFO read data arrives one cycle after the pop strobe, which is why a one-cycle FETCH state exists.
module fifo_uart_tx #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_uart_tx_if.slave        bus
);

  localparam int N  = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(N - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_nx_s;
  logic             line_q, line_d;
  logic             busy_q, busy_d;
  logic             rd_en_s;

  // Pop is combinational so that the word is requested in the very IDLE cycle; gated by rst so reset never pops.
  assign rd_en_s    = rst && (state_q == IDLE) && !bus.fifo_empty && bus.tx_enable;
  assign shift_nx_s = shift_q >> 1;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (rd_en_s) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        shift_d = bus.fifo_dout;
        line_d  = 1'b0;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          line_d  = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            line_d  = 1'b1;
            state_d = STOP;
          end else begin
            // The shift register keeps the current bit at position 0.
            bit_d   = bit_q + BW'(1);
            shift_d = shift_nx_s;
            line_d  = shift_nx_s[0];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        line_d = 1'b1;
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        line_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drives the line high immediately, abandoning any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_s;
  assign bus.serial_out = line_q;
  assign bus.busy       = busy_q;

endmodule
